// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressable data memory with RISC-V load/store sizing
// Single-port word array; loads are registered once (READ_LAT=1) or twice (READ_LAT=2).
module data_memory_sized #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    // Power-up image: words 0 and 1 carry seed values, everything else is zero.
    logic [31:0] mem [DEPTH] = '{0: 32'd8, 1: 32'd1, default: 32'd0};

    logic          legal;
    logic          is_unsigned;
    logic [1:0]    size;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wd;

    always_comb begin
        legal       = 1'b0;
        is_unsigned = 1'b0;
        size        = 2'd0;
        case (funct3)
            3'b000: begin legal = 1'b1; size = 2'd0; end
            3'b001: begin legal = 1'b1; size = 2'd1; end
            3'b010: begin legal = 1'b1; size = 2'd2; end
            3'b100: begin legal = !we; size = 2'd0; is_unsigned = 1'b1; end
            3'b101: begin legal = !we; size = 2'd1; is_unsigned = 1'b1; end
            default: begin legal = 1'b0; size = 2'd0; end
        endcase
    end

    assign misaligned   = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
    assign out_of_range = |addr[31:AW+2];
    assign acc_err      = !legal || misaligned || out_of_range;
    assign idx          = addr[AW+1:2];
    assign word         = mem[idx];

    always_comb begin
        lane_byte = word[{addr[1:0], 3'b000} +: 8];
        lane_half = addr[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    ld_data = is_unsigned ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'd1:    ld_data = is_unsigned ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        case (size)
            2'd0:    begin be = 4'b0001 << addr[1:0];               wd = {4{wdata[7:0]}};  end
            2'd1:    begin be = addr[1] ? 4'b1100 : 4'b0011;        wd = {2{wdata[15:0]}}; end
            default: begin be = 4'b1111;                            wd = wdata;            end
        endcase
    end

    // Memory is never reset; rejected stores and stores under reset leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst && req && we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    logic        s1_valid;
    logic        s1_err;
    logic [31:0] s1_data;

    // err travels for stores too; rdata is forced to zero unless a good load is in the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= 32'd0;
        end else begin
            s1_valid <= req && !we;
            s1_err   <= req && acc_err;
            s1_data  <= (req && !we && !acc_err) ? ld_data : 32'd0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        s2_valid;
            logic        s2_err;
            logic [31:0] s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= 32'd0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    s2_data  <= s1_data;
                end
            end

            assign rvalid = s2_valid;
            assign err    = s2_err;
            assign rdata  = s2_data;
        end else begin : g_lat1
            assign rvalid = s1_valid;
            assign err    = s1_err;
            assign rdata  = s1_data;
        end
    endgenerate
endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - directed and random checks of data_memory_sized at both latencies
// Both latency variants see identical stimulus and are compared against a byte-array model.
module tb_data_memory_sized;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic        err1, err2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t       p1, p2;
    logic [7:0] mb [4*DEPTH];

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH(DEPTH), .READ_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .err(err1)
    );

    data_memory_sized #(.DEPTH(DEPTH), .READ_LAT(2)) dut_l2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata2), .rvalid(rvalid2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access decoded from the funct3 table.
    function automatic exp_t ref_access(input logic w, input logic [2:0] f,
                                        input logic [31:0] a, input logic [31:0] d);
        exp_t        r;
        int          n;
        bit          sgn;
        bit          ok;
        logic [31:0] v;
        n = 1; sgn = 0; ok = 1;
        case (f)
            3'b000: begin n = 1; sgn = 1; end
            3'b001: begin n = 2; sgn = 1; end
            3'b010: begin n = 4; sgn = 0; end
            3'b100: begin n = 1; ok = !w; end
            3'b101: begin n = 2; ok = !w; end
            default: ok = 0;
        endcase
        if ((a % n) != 0 || a >= 4*DEPTH) ok = 0;
        r.v = !w;
        r.e = !ok;
        r.d = 32'd0;
        if (ok) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[a+i]) << (8*i));
                if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                r.d = v;
            end
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic q, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t cur;
        rst = r; req = q; we = w; funct3 = f; addr = a; wdata = d;
        cur = '0;
        if (!r && q) cur = ref_access(w, f, a, d);
        @(posedge clk);
        if (r) begin
            p1 = '0;
            p2 = '0;
        end else begin
            p2 = p1;
            p1 = cur;
        end
        @(negedge clk);
        check("rvalid_lat1", 32'(rvalid1), 32'(p1.v));
        check("err_lat1",    32'(err1),    32'(p1.e));
        check("rdata_lat1",  rdata1,       p1.d);
        check("rvalid_lat2", 32'(rvalid2), 32'(p2.v));
        check("err_lat2",    32'(err2),    32'(p2.e));
        check("rdata_lat2",  rdata2,       p2.d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
        mb[0] = 8'h08;
        mb[4] = 8'h01;
        p1 = '0;
        p2 = '0;

        step(1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check("reset_rvalid", 32'(rvalid1 | rvalid2), 32'd0);
        check("reset_rdata",  rdata1 | rdata2, 32'd0);

        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
        check("lw0_lat1", rdata1, 32'h0000_0008);
        idle();
        check("lw0_lat2", rdata2, 32'h0000_0008);

        step(1'b0, 1'b1, 1'b1, 3'b010, 32'h8, 32'h80FF_7F01);
        step(1'b0, 1'b1, 1'b0, 3'b000, 32'h8, 32'd0);
        check("lb8", rdata1, 32'h0000_0001);
        step(1'b0, 1'b1, 1'b0, 3'b100, 32'h9, 32'd0);
        check("lbu9", rdata1, 32'h0000_007F);
        step(1'b0, 1'b1, 1'b0, 3'b001, 32'hA, 32'd0);
        check("lhA", rdata1, 32'hFFFF_80FF);
        step(1'b0, 1'b1, 1'b0, 3'b101, 32'hA, 32'd0);
        check("lhuA", rdata1, 32'h0000_80FF);

        step(1'b0, 1'b1, 1'b1, 3'b000, 32'hD, 32'h0000_00AA);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'hC, 32'd0);
        check("sb_lwC", rdata1, 32'h0000_AA00);

        step(1'b0, 1'b1, 1'b0, 3'b001, 32'h3, 32'd0);
        check("lh3_err", 32'(err1 & rvalid1), 32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h6, 32'd0);
        check("lw6_err", 32'(err1 & rvalid1), 32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b011, 32'h0, 32'd0);
        check("f011_err", 32'(err1 & rvalid1), 32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'(4*DEPTH), 32'd0);
        check("oor_err", 32'(err1 & rvalid1), 32'd1);
        check("oor_rdata", rdata1, 32'd0);
        step(1'b0, 1'b1, 1'b1, 3'b010, 32'h2, 32'hDEAD_BEEF);
        check("sw2_err", 32'(err1 & !rvalid1), 32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
        check("sw2_nowrite", rdata1, 32'h0000_0008);
        check("sw2_err_lat2", 32'(err2 & !rvalid2), 32'd1);

        step(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        check("raw_lat1", rdata1, 32'h1234_5678);
        idle();
        check("raw_lat2", rdata2, 32'h1234_5678);

        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        step(1'b1, 1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFF_FFFF);
        check("flush_lat2", 32'(rvalid2), 32'd0);
        idle();
        check("flush_lat2_after", 32'(rvalid2), 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        check("preserved", rdata1, 32'h1234_5678);

        for (int n = 0; n < 400; n++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 3));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), f, a, $urandom);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
